fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Fetch stage directly downstream of the free-running program counter.
- Each enabled cycle, presents the counter value as the instruction-memory address and captures the returned word one cycle later.
- Pushes the {pc, instruction} pair into a small FIFO, which decode drains with a valid/ready handshake.
- The counter cannot stall, so the queue absorbs decode back-pressure and flags any lost fetch.

Parameters:
ADDR_W, 32, width of pc_in / imem_addr / out_pc
DATA_W, 32, instruction word width
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
fetch_en  input  1  issue a fetch this cycle using pc_in
flush  input  1  discard queue contents and in-flight fetch
pc_in  input  ADDR_W  current counter value
imem_addr  output  ADDR_W  instruction memory address (combinational = pc_in)
imem_rdata  input  DATA_W  synchronous-read data, valid one cycle after address
out_valid  output  1  head entry available
out_ready  input  1  decode accepts head entry
out_pc  output  ADDR_W  pc of head entry
out_instr  output  DATA_W  instruction of head entry
count  output  $clog2(DEPTH)+1  occupied entries
overflow  output  1  sticky: a returned fetch was dropped

Behaviour:
- Reset (rst=1 at edge): count=0, out_valid=0, overflow=0, in-flight valid=0. Read/write pointers=0. out_pc/out_instr=0.
- rst has priority over flush, and flush over all other activity.
- Issue:
  - issue = fetch_en & ~rst & ~flush.
  - imem_addr = pc_in always, combinational. It is not gated, since memory reads are side-effect free.
  - On issue, register inflight_v=1 and inflight_pc=pc_in; otherwise inflight_v=0.
- Return:
  - In cycle t+1 after an issue in cycle t, push = inflight_v & ~flush, with data {inflight_pc, imem_rdata}.
  - The entry is written at the end of t+1.
  - It becomes visible at the head (out_valid=1 if queue was empty) in cycle t+2.
  - Issue-to-out_valid latency = 2 cycles.
- Pop: pop = out_valid & out_ready & ~flush. The head advances at the edge, and the next entry is visible the following cycle.
- out_valid = (count != 0). out_pc/out_instr are driven from the head entry and are stable while out_valid & ~out_ready.
- Full: push with count==DEPTH and no pop → entry dropped, count unchanged, overflow set. overflow clears only on rst.
- Simultaneous push and pop:
  - Allowed at any count, including full (entry accepted, no overflow).
  - Also allowed at count==1 (head replaced by new entry next cycle).
  - count unchanged.
- Empty: pop is impossible (out_valid=0), and out_ready is ignored.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Flush:
  - At the edge: count=0, pointers=0, inflight_v=0.
  - Any imem_rdata returning in the flush cycle is discarded.
  - The fetch issued in the cycle after flush deasserts follows normal latency.
  - overflow is unaffected.
- Reset mid-operation: all queued and in-flight entries are lost, and out_valid=0 the cycle after the reset edge.
- Order: entries leave in issue order. No reordering, no duplication.

Test Plan:
- Basic:
  - rst, then fetch_en=1 with pc_in 0,1,2,3 on consecutive cycles; imem returns pc+0x100; out_ready=1.
  - → out_valid first high 2 cycles after first issue.
  - → out_pc/out_instr = (0,0x100),(1,0x101),(2,0x102),(3,0x103) on consecutive cycles; count never exceeds 1.
- Back-pressure/full:
  - DEPTH=4, out_ready=0, fetch pc 0..5.
  - → count saturates at 4 and overflow=1 after the 5th return.
  - → raise out_ready: pops pc 0,1,2,3 only.
  - → overflow stays 1 until rst.
- Full with simultaneous push/pop: count=4 and out_ready=1 while fetching continues → no overflow, count stays 4, pcs exit in strict order.
- Flush:
  - Two entries queued plus one in flight; assert flush one cycle.
  - → next cycle count=0, out_valid=0, and the in-flight word never appears.
  - → fetch pc 7 after flush → out_pc=7 two cycles later.
- Reset mid-stream: rst while count=3 and overflow=1 → next cycle count=0, out_valid=0, overflow=0; subsequent fetch of pc 0 emerges after 2 cycles.
- Gaps: fetch_en toggling 1,0,1 with pc 10,11,12 → only entries for pc 10 and 12 are output, in order.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage behind the free-running program counter: issues pc_in to the
// instruction memory, pairs the returned word with its pc and queues it for decode.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        pc_in,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Control state (reset) and datapath state (not reset)
  logic              vld_p1_q, vld_p1_d;
  logic [ADDR_W-1:0] pc_p1_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] mem_pc_q    [DEPTH];
  logic [DATA_W-1:0] mem_instr_q [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic full;
  logic wr_en;

  // Next count: one step up on an accepted push, one step down on a pop.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic            inc,
                                                  input logic            dec);
    logic [CNT_W-1:0] res;
    res = cur;
    if (inc && !dec) res = cur + CNT_W'(1);
    else if (dec && !inc) res = cur - CNT_W'(1);
    return res;
  endfunction

  assign imem_addr = pc_in;

  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Head outputs read zero while empty so the reset state is defined
  // without resetting the storage array.
  assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;

  always_comb begin
    issue      = fetch_en & ~flush;
    push       = vld_p1_q & ~flush;
    pop        = out_valid & out_ready & ~flush;
    full       = (count_q == CNT_W'(DEPTH));
    wr_en      = push & (~full | pop);

    vld_p1_d   = issue;
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = next_count(count_q, wr_en, pop);
    overflow_d = overflow_q | (push & full & ~pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Stage p0 -> p1: fetch issued, memory read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1_q <= pc_in;
  end

  // Stage p1 -> queue: returned word paired with its pc
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_pc_q[wr_ptr_q]    <= pc_p1_q;
      mem_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed fetch sequences push expected
// {pc, instr} pairs; a monitor pops and compares on every accepted head entry.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t exp_q[$];

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .pc_in      (pc_in),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word = address + 0x100
  always @(posedge clk) imem_rdata <= imem_addr + 32'h100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [31:0] pc, input bit keep);
    ent_t e;
    @(posedge clk); #1;
    fetch_en = en;
    pc_in    = pc;
    if (en && keep) begin
      e.pc    = pc;
      e.instr = pc + 32'h100;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every accepted head entry must match the oldest expected pair
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc=%0h instr=%0h expected none", out_pc, out_instr);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_pair", {out_pc, out_instr}, {e.pc, e.instr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    rst = 1'b0;

    // Basic streaming with decode always ready
    out_ready = 1'b1;
    cyc(1'b1, 32'd0, 1'b1);
    chk("basic_valid_t0", out_valid, 0);
    cyc(1'b1, 32'd1, 1'b1);
    chk("basic_valid_t1", out_valid, 0);
    cyc(1'b1, 32'd2, 1'b1);
    chk("basic_valid_t2", out_valid, 1);
    chk("basic_head_pc", out_pc, 0);
    cyc(1'b1, 32'd3, 1'b1);
    chk("basic_cnt", count <= 3'd1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 1'b0);
      chk("basic_cnt", count <= 3'd1, 1);
    end
    chk("basic_empty", count, 0);

    // Back-pressure until full, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i), i < 4);
    cyc(1'b0, 32'd0, 1'b0);
    chk("bp_count_full", count, 4);
    chk("bp_ovf_set", overflow, 1);
    chk("bp_head_stable", out_pc, 0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("bp_count_hold", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 1'b0);
    chk("bp_drained", count, 0);
    chk("bp_valid_low", out_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop
    do_reset();
    chk("full_ovf_cleared", overflow, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 32'(20 + i), 1'b1);
      if (i >= 5) begin
        chk("full_pp_count", count, 4);
        chk("full_pp_ovf", overflow, 0);
      end
      if (i == 5) out_ready = 1'b1;
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b0);
    chk("full_pp_drained", count, 0);
    chk("full_pp_ovf_end", overflow, 0);

    // Flush with two queued entries and one in flight
    do_reset();
    cyc(1'b1, 32'd40, 1'b0);
    cyc(1'b1, 32'd41, 1'b0);
    cyc(1'b1, 32'd42, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("flush_pre_count", count, 2);
    flush = 1'b1;
    cyc(1'b1, 32'd7, 1'b1);
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("flush_lat_valid", out_valid, 0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("flush_new_valid", out_valid, 1);
    chk("flush_new_pc", out_pc, 7);
    chk("flush_new_instr", out_instr, 32'h107);
    out_ready = 1'b1;
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("flush_drained", count, 0);

    // Reset in the middle of a stream with overflow set
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(50 + i), i == 0);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("mid_ovf_set", overflow, 1);
    out_ready = 1'b1;
    cyc(1'b0, 32'd0, 1'b0);
    out_ready = 1'b0;
    chk("mid_count3", count, 3);
    chk("mid_ovf_pre", overflow, 1);
    rst = 1'b1;
    cyc(1'b1, 32'd0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("mid_lat_valid", out_valid, 0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("mid_new_valid", out_valid, 1);
    chk("mid_new_pc", out_pc, 0);
    out_ready = 1'b1;

    // Gaps in fetch_en
    cyc(1'b1, 32'd10, 1'b1);
    cyc(1'b0, 32'd11, 1'b0);
    cyc(1'b1, 32'd12, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b0);
    chk("gap_drained", count, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
